// File: rtl/conv_bank_rotator_if.sv
// Host/FSM-facing bus of the column bank rotator: load, process and readout controls plus window/result outputs.
// master = FSM/host side, slave = bank rotator.
interface conv_bank_rotator_if #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_DATA    = 8
);
    logic                  i_load;
    logic                  i_EoP;
    logic                  i_changeBlock;
    logic                  i_fms2conVld;
    logic [NB_ADDRESS-1:0] i_writeAdd;
    logic [NB_ADDRESS-1:0] i_readAdd;
    logic [NB_DATA-1:0]    i_wrData;
    logic                  i_wrEn;
    logic [NB_DATA-1:0]    i_convData;
    logic                  i_convVld;
    logic [NB_DATA-1:0]    o_pix0;
    logic [NB_DATA-1:0]    o_pix1;
    logic [NB_DATA-1:0]    o_pix2;
    logic                  o_pixVld;
    logic [NB_DATA-1:0]    o_rdData;
    logic                  o_rdVld;
    logic                  o_ready;

    modport master (
        output i_load, i_EoP, i_changeBlock, i_fms2conVld, i_writeAdd, i_readAdd,
               i_wrData, i_wrEn, i_convData, i_convVld,
        input  o_pix0, o_pix1, o_pix2, o_pixVld, o_rdData, o_rdVld, o_ready
    );

    modport slave (
        input  i_load, i_EoP, i_changeBlock, i_fms2conVld, i_writeAdd, i_readAdd,
               i_wrData, i_wrEn, i_convData, i_convVld,
        output o_pix0, o_pix1, o_pix2, o_pixVld, o_rdData, o_rdVld, o_ready
    );
endinterface

// File: rtl/conv_bank_rotator.sv
// Four column banks with rotating W0/W1/W2/S roles; presents a 3-column window and drains results back to the host.
// 1-cycle registered read latency on window and readout; no backpressure, the FSM paces every access.
module conv_bank_rotator #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_DATA    = 8
) (
    input  logic              i_CLK,
    input  logic              i_reset,
    conv_bank_rotator_if.slave bus
);
    localparam int DEPTH = 1 << NB_ADDRESS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PROC  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [NB_DATA-1:0] r_mem [4][DEPTH];

    logic [1:0]         r_state;
    logic [1:0]         r_base;
    logic [1:0]         r_fill;
    logic               r_load_pend;
    logic               r_eop_d;
    logic [NB_DATA-1:0] r_pix0;
    logic [NB_DATA-1:0] r_pix1;
    logic [NB_DATA-1:0] r_pix2;
    logic               r_pix_vld;
    logic [NB_DATA-1:0] r_rd_data;
    logic               r_rd_vld;
    logic               r_ready;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_w0_idx;
    logic [1:0]         w_w1_idx;
    logic [1:0]         w_w2_idx;
    logic [1:0]         w_s_idx;
    logic               w_ld_wr;
    logic               w_cv_wr;
    logic [NB_DATA-1:0] w_mem_wd;
    logic               w_rotate;
    logic               w_eop_rise;

    // Roles are pure pointer arithmetic; 2-bit wrap gives the mod-4 rotation for free.
    assign w_w0_idx   = r_base;
    assign w_w1_idx   = r_base + 2'd1;
    assign w_w2_idx   = r_base + 2'd2;
    assign w_s_idx    = r_base + 2'd3;

    assign w_ld_wr    = (r_state == S_LOAD) && bus.i_wrEn;
    assign w_cv_wr    = (r_state == S_PROC) && bus.i_convVld;
    assign w_mem_wd   = w_ld_wr ? bus.i_wrData : bus.i_convData;
    assign w_rotate   = bus.i_changeBlock && r_load_pend;
    assign w_eop_rise = bus.i_EoP && !r_eop_d;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_load)            w_state_nxt = S_LOAD;
                else if (bus.i_fms2conVld) w_state_nxt = S_PROC;
                else if (bus.i_EoP)        w_state_nxt = S_DRAIN;
            end
            S_LOAD:  if (bus.i_changeBlock)               w_state_nxt = S_IDLE;
            S_PROC:  if (bus.i_changeBlock || w_eop_rise) w_state_nxt = S_IDLE;
            default: if (bus.i_changeBlock)               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_base      <= 2'd0;
            r_fill      <= 2'd0;
            r_load_pend <= 1'b0;
            r_eop_d     <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_eop_d <= bus.i_EoP;
            r_ready <= (r_fill == 2'd3);
            if (w_rotate) begin
                r_base      <= r_base + 2'd1;
                r_load_pend <= 1'b0;
                if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
            end else if (w_ld_wr) begin
                r_load_pend <= 1'b1;
            end
        end
    end

    // Bank contents survive reset; reset forces IDLE, which already blocks every write.
    always_ff @(posedge i_CLK) begin
        if (w_ld_wr || w_cv_wr) r_mem[w_s_idx][bus.i_writeAdd] <= w_mem_wd;
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_pix0    <= '0;
            r_pix1    <= '0;
            r_pix2    <= '0;
            r_pix_vld <= 1'b0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_pix_vld <= (r_state == S_PROC) && bus.i_fms2conVld && r_ready;
            r_rd_vld  <= (r_state == S_DRAIN);
            if (r_state == S_PROC) begin
                r_pix0 <= r_mem[w_w0_idx][bus.i_readAdd];
                r_pix1 <= r_mem[w_w1_idx][bus.i_readAdd];
                r_pix2 <= r_mem[w_w2_idx][bus.i_readAdd];
            end
            if (r_state == S_DRAIN) r_rd_data <= r_mem[w_s_idx][bus.i_readAdd];
        end
    end

    assign bus.o_pix0   = r_pix0;
    assign bus.o_pix1   = r_pix1;
    assign bus.o_pix2   = r_pix2;
    assign bus.o_pixVld = r_pix_vld;
    assign bus.o_rdData = r_rd_data;
    assign bus.o_rdVld  = r_rd_vld;
    assign bus.o_ready  = r_ready;
endmodule

// File: doc/conv_bank_rotator.md
Name: conv_bank_rotator

Overview:
- Memory stage directly downstream of the address/control FSM.
- Owns four column banks. It stores host-loaded image columns and presents a 3-column window to the convolver.
- It writes convolver results back into a bank and returns them to the host on readout.
- Consumes the FSM's write/read addresses, changeBlock, EoP and convolver-valid strobes. Rotates bank roles so no column data is copied.

Parameters:
NB_ADDRESS, 10, bank address width; each bank is 2^NB_ADDRESS words
NB_DATA, 8, pixel/result word width

Ports:
i_CLK  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_load  input  1  host load phase active
i_EoP  input  1  FSM end-of-process (readout phase)
i_changeBlock  input  1  FSM block-done strobe
i_fms2conVld  input  1  FSM convolver-valid
i_writeAdd  input  NB_ADDRESS  FSM write address
i_readAdd  input  NB_ADDRESS  FSM read address
i_wrData  input  NB_DATA  host pixel
i_wrEn  input  1  host pixel strobe (level, one word per cycle)
i_convData  input  NB_DATA  convolver result
i_convVld  input  1  convolver result valid
o_pix0  output  NB_DATA  window oldest column pixel
o_pix1  output  NB_DATA  window middle column pixel
o_pix2  output  NB_DATA  window newest column pixel
o_pixVld  output  1  window pixels valid
o_rdData  output  NB_DATA  result word to host
o_rdVld  output  1  result word valid
o_ready  output  1  three columns loaded, window usable

Behaviour:
- Async reset (i_reset=0):
  - all outputs 0; state IDLE; base=0; fill=0; loadPend=0.
  - Bank contents are not cleared.
- Roles: base is a 2-bit pointer.
  - W0=bank[base], W1=bank[base+1], W2=bank[base+2], S=bank[base+3], all mod 4.
- FSM states: IDLE, LOAD, PROC, DRAIN.
  - IDLE->LOAD when i_load=1.
  - IDLE->PROC when i_fms2conVld=1 and i_load=0.
  - IDLE->DRAIN when i_EoP=1 and i_load=0.
  - If several conditions are true at once, priority is LOAD > PROC > DRAIN.
  - LOAD, PROC and DRAIN each return to IDLE on i_changeBlock.
  - PROC also returns to IDLE on i_EoP rising edge, which covers the FSM dropping valid before EoP.
- LOAD:
  - i_wrEn=1 writes i_wrData to S[i_writeAdd] and sets loadPend=1.
  - i_convVld is ignored.
- Rotation: on i_changeBlock with loadPend=1:
  - base<=base+1 (wraps 3->0), loadPend<=0, fill<=min(fill+1,3).
  - The new column becomes W2 and the old W0 becomes S.
- i_changeBlock with loadPend=0 (after DRAIN) performs no rotation; it only returns to IDLE.
- Synchronous read latency is 1 cycle for all bank reads.
- PROC:
  - Each cycle, read W0/W1/W2 at i_readAdd.
  - o_pix0..2 register the read data.
  - o_pixVld = i_fms2conVld delayed 1 cycle, gated by o_ready.
  - i_convVld=1 writes i_convData to S[i_writeAdd].
    - Write to S is safe: W0 is still read this block, and S is not read until DRAIN.
  - If o_ready=0 in PROC: no pixel valid is asserted; result writes still occur.
- DRAIN:
  - Read S at i_readAdd; o_rdData registers it; o_rdVld = (state==DRAIN) delayed 1 cycle.
  - After DRAIN, S is overwritten by the next LOAD (results already consumed).
- o_ready = (fill==3), registered. It stays 1 until reset.
- Same-cycle read/write on the same bank and address returns the old data (read-first).
- Address inputs are used as-is, full NB_ADDRESS width, with no bounds check.
- i_wrEn outside LOAD and i_convVld outside PROC are ignored; no write occurs.
- Reset mid-operation: state, base, fill and loadPend return to reset values immediately; an in-flight write is dropped.

Test Plan:
1. Reset then load 3 columns:
   - Stimulus: load col k with pixel value 16*k+addr, addr 0..3, each load followed by changeBlock.
   - Required: base=3, fill=3, o_ready=1 exactly one cycle after the 3rd changeBlock.
2. PROC window read:
   - Stimulus: after scenario 1, fms2conVld=1, readAdd=2.
   - Required: o_pix0=0x02, o_pix1=0x12, o_pix2=0x22, o_pixVld=1 one cycle later.
3. Result write and DRAIN:
   - Stimulus: convVld with writeAdd=0..3 and data 0xA0..0xA3; then EoP=1 with readAdd=0..3.
   - Required: o_rdData=0xA0..0xA3, each 1 cycle after its address, o_rdVld=1.
4. changeBlock after DRAIN:
   - Required: base unchanged.
   - A 4th load plus changeBlock then gives base=0, and the window pixels are cols 1,2,3.
5. Wrap-around: after 8 rotations, base=0 and fill stays 3.
6. Reset mid-LOAD:
   - Stimulus: drop i_reset between two i_wrEn cycles.
   - Required: all outputs 0 asynchronously; base=0; the next changeBlock does not rotate.
